// File: rtl/m6502_pkg.sv
// ---- m6502_pkg: shared ALU opcodes, RMW operation encoding and sequencer states (rev 1.0) ----
`default_nettype none

package m6502_pkg;

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [7:0] ALU_SHL = 8'h11;
  localparam logic [7:0] ALU_SHR = 8'h13;
  localparam logic [7:0] ALU_INC = 8'h22;
  localparam logic [7:0] ALU_DEC = 8'h24;

  typedef enum logic [2:0] {
    RMW_ASL  = 3'd0,
    RMW_LSR  = 3'd1,
    RMW_ROL  = 3'd2,
    RMW_ROR  = 3'd3,
    RMW_INC  = 3'd4,
    RMW_DEC  = 3'd5,
    RMW_RSV6 = 3'd6,
    RMW_RSV7 = 3'd7
  } rmw_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DWRITE = 3'd3,
    ST_FWRITE = 3'd4
  } rmw_state_e;

  function automatic logic is_shift(input rmw_op_e op);
    return (op == RMW_ASL) || (op == RMW_LSR) || (op == RMW_ROL) || (op == RMW_ROR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/m6502_rmw_sequencer.sv
// ---- m6502_rmw_sequencer: 6502 read / dummy-write / final-write sequence with external ALU (rev 1.0) ----
`default_nettype none

module m6502_rmw_sequencer
  import m6502_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [2:0]            rmw_op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  c_in,
  output logic                  ready,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wr_data,
  input  logic [7:0]            mem_rd_data,
  output logic [7:0]            alu_operation,
  output logic [7:0]            alu_op_a,
  output logic [7:0]            alu_op_b,
  output logic                  alu_carry_in,
  input  logic [7:0]            alu_result,
  input  logic                  alu_carry,
  output logic                  flags_we,
  output logic                  c_out,
  output logic                  z_out,
  output logic                  n_out
);

  rmw_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  rmw_op_e               op_q;
  logic                  cin_q;
  logic [7:0]            operand_q;
  logic [7:0]            result_q;
  logic                  carry_q;
  logic                  op_valid;

  assign op_valid = (op_q <= RMW_DEC);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      op_q      <= RMW_ASL;
      cin_q     <= 1'b0;
      operand_q <= 8'h00;
      result_q  <= 8'h00;
      carry_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q <= addr;
            op_q   <= rmw_op_e'(rmw_op);
            cin_q  <= c_in;
          end
        end
        ST_WAIT:   operand_q <= mem_rd_data;
        ST_DWRITE: begin
          result_q <= alu_result;
          carry_q  <= alu_carry;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    ready         = 1'b0;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wr_data   = 8'h00;
    alu_operation = 8'h00;
    alu_op_a      = 8'h00;
    alu_op_b      = 8'h00;
    alu_carry_in  = 1'b0;
    flags_we      = 1'b0;
    c_out         = 1'b0;
    z_out         = 1'b0;
    n_out         = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = ST_READ;
      end
      ST_READ: begin
        mem_cs    = 1'b1;
        mem_addr  = addr_q;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: state_nxt = ST_DWRITE;
      ST_DWRITE: begin
        // The 6502 writes the unmodified value back while the ALU works on it.
        mem_cs      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = addr_q;
        mem_wr_data = operand_q;
        alu_op_a    = operand_q;
        case (op_q)
          RMW_ASL: alu_operation = ALU_SHL;
          RMW_ROL: begin alu_operation = ALU_SHL; alu_carry_in = cin_q; end
          RMW_LSR: alu_operation = ALU_SHR;
          RMW_ROR: begin alu_operation = ALU_SHR; alu_carry_in = cin_q; end
          RMW_INC: alu_operation = ALU_INC;
          RMW_DEC: alu_operation = ALU_DEC;
          default: alu_operation = ALU_NOP;
        endcase
        state_nxt = ST_FWRITE;
      end
      ST_FWRITE: begin
        mem_cs      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = addr_q;
        mem_wr_data = result_q;
        flags_we    = op_valid;
        if (op_valid) begin
          // INC/DEC leave C untouched, so the captured flag is echoed back.
          c_out = is_shift(op_q) ? carry_q : cin_q;
          z_out = (result_q == 8'h00);
          n_out = result_q[7];
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_m6502_rmw_sequencer.sv
// ---- tb_m6502_rmw_sequencer: directed vectors with write/flag scoreboard (rev 1.0) ----
`default_nettype none

module tb_m6502_rmw_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  rmw_op = 3'd0;
  logic [15:0] addr = 16'h0000;
  logic        c_in = 1'b0;
  logic        ready, mem_cs, mem_we, flags_we, c_out, z_out, n_out;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data = 8'h00;
  logic [7:0]  alu_operation, alu_op_a, alu_op_b, alu_result;
  logic        alu_carry_in, alu_carry;

  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0000;
  logic [7:0]  pre_data = 8'h00;
  logic [7:0]  mem [0:65535];

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic c; logic z; logic n; } fl_t;
  wr_t wq[$];
  fl_t fq[$];

  int n_vec = 0;
  int n_fail = 0;
  int n_reads = 0;

  always #5 clk = ~clk;

  m6502_rmw_sequencer #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rmw_op(rmw_op), .addr(addr), .c_in(c_in),
    .ready(ready), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .alu_operation(alu_operation), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry(alu_carry),
    .flags_we(flags_we), .c_out(c_out), .z_out(z_out), .n_out(n_out)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_cs && mem_we) mem[mem_addr] <= mem_wr_data;
    if (mem_cs && !mem_we) mem_rd_data <= mem[mem_addr];
  end

  // Reference ALU: shifts pull carry_in into the vacated bit; 0x00 passes A through.
  always_comb begin
    alu_result = alu_op_a;
    alu_carry  = 1'b0;
    case (alu_operation)
      8'h11: begin alu_result = {alu_op_a[6:0], alu_carry_in}; alu_carry = alu_op_a[7]; end
      8'h13: begin alu_result = {alu_carry_in, alu_op_a[7:1]}; alu_carry = alu_op_a[0]; end
      8'h22: alu_result = alu_op_a + 8'h01;
      8'h24: alu_result = alu_op_a - 8'h01;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t ew;
    fl_t ef;
    if (mem_cs === 1'b1 && mem_we === 1'b0) n_reads++;
    if (mem_cs === 1'b1 && mem_we === 1'b1) begin
      if (wq.size() == 0) check("unexpected_write", {16'h0, mem_addr}, 32'hFFFF_FFFF);
      else begin
        ew = wq.pop_front();
        check("wr_addr", {16'h0, mem_addr}, {16'h0, ew.a});
        check("wr_data", {24'h0, mem_wr_data}, {24'h0, ew.d});
      end
    end
    if (flags_we === 1'b1) begin
      if (fq.size() == 0) check("unexpected_flags_we", 32'd1, 32'd0);
      else begin
        ef = fq.pop_front();
        check("flags_czn", {29'h0, c_out, z_out, n_out}, {29'h0, ef.c, ef.z, ef.n});
      end
    end
  end

  // mode 0: plain op, 1: extra start pulsed during WAIT, 2: reset asserted during DWRITE
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [7:0] init,
                        input logic cin, input logic [7:0] res, input logic fl,
                        input logic c, input logic z, input logic n, input int mode);
    int reads0;
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = init;
    @(negedge clk);
    pre_we = 1'b0;
    wq.push_back('{a: a, d: init});
    if (mode != 2) wq.push_back('{a: a, d: res});
    if (fl && mode != 2) fq.push_back('{c: c, z: z, n: n});
    reads0 = n_reads;
    for (int k = 0; k < 20 && ready !== 1'b1; k++) @(negedge clk);
    check("ready_before_start", {31'h0, ready}, 32'd1);
    start = 1'b1; rmw_op = op; addr = a; c_in = cin;
    @(negedge clk);
    start = 1'b0; rmw_op = 3'd5; addr = 16'hDEAD; c_in = ~cin;
    check("read_cycle", {30'h0, ready, mem_cs, mem_we}, {30'h0, 3'b010});
    check("read_addr", {16'h0, mem_addr}, {16'h0, a});
    @(negedge clk);
    if (mode == 1) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mode == 2) reset_n = 1'b0;
    @(negedge clk);
    if (mode == 2) begin
      check("abort_idle", {29'h0, ready, mem_cs, flags_we}, {29'h0, 3'b100});
      reset_n = 1'b1;
    end else begin
      check("busy_at_T4", {31'h0, ready}, 32'd0);
      @(negedge clk);
      check("ready_at_T5", {31'h0, ready}, 32'd1);
    end
    @(negedge clk);
    check("still_idle", {30'h0, ready, mem_cs}, {30'h0, 2'b10});
    check("read_count", n_reads - reads0, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready_cs_we", {29'h0, ready, mem_cs, mem_we}, {29'h0, 3'b100});
    check("rst_addr_data", {8'h0, mem_addr, mem_wr_data}, 32'h0);
    check("rst_alu", {15'h0, alu_operation, alu_op_a, alu_carry_in}, 32'h0);
    check("rst_flags", {28'h0, flags_we, c_out, z_out, n_out}, 32'h0);
    reset_n = 1'b1;
    //     op    addr       init   cin   res    fl    C     Z     N     mode
    run_op(3'd0, 16'h0200, 8'h81, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 0); // ASL
    run_op(3'd3, 16'h0210, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 0); // ROR
    run_op(3'd4, 16'h0220, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0); // INC wrap
    run_op(3'd5, 16'h0230, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 0); // DEC wrap
    run_op(3'd1, 16'h0240, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0); // LSR
    run_op(3'd2, 16'h0250, 8'h40, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 0); // ROL
    run_op(3'd7, 16'h0260, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0); // reserved
    run_op(3'd4, 16'h0300, 8'h10, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1); // start in WAIT
    run_op(3'd0, 16'h0400, 8'h81, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 2); // reset in DWRITE
    repeat (3) @(negedge clk);
    check("writes_outstanding", wq.size(), 32'd0);
    check("flags_outstanding", fq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
